// File: rtl/softmax_argmax.sv
// Final classification stage: walks the softmax probabilities one per clock and
// reports the index, value and one-hot vector of the largest entry.
module softmax_argmax #(
  parameter int DATA_WIDTH = 32,
  parameter int INPUT_NUM  = 10
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [DATA_WIDTH*INPUT_NUM-1:0]  inputs,
  input  logic                             enable,
  output logic [3:0]                       classIndex,
  output logic [DATA_WIDTH-1:0]            classValue,
  output logic [INPUT_NUM-1:0]             classOneHot,
  output logic                             ackArg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(INPUT_NUM - 1);

  state_t                  state_q;
  logic [3:0]              counter_q;
  logic [DATA_WIDTH-1:0]   best_q;
  logic [3:0]              best_idx_q;
  logic [3:0]              class_index_q;
  logic [DATA_WIDTH-1:0]   class_value_q;
  logic [INPUT_NUM-1:0]    class_onehot_q;
  logic                    ack_q;

  logic [DATA_WIDTH-1:0]   elem_tbl [16];
  logic [DATA_WIDTH-1:0]   cur_elem;
  logic                    take_elem;
  logic [DATA_WIDTH-1:0]   best_d;
  logic [3:0]              best_idx_d;
  logic [INPUT_NUM-1:0]    onehot_d;

  // Sign-magnitude "a strictly greater than b"; NaN on either side never wins,
  // and the two zeros compare equal.
  function automatic logic float_gt(input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b);
    logic a_nan;
    logic b_nan;
    logic gt;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    gt    = 1'b0;
    if (a_nan || b_nan) begin
      gt = 1'b0;
    end else if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
      gt = 1'b0;
    end else if (!a[31] && b[31]) begin
      gt = 1'b1;
    end else if (a[31] && !b[31]) begin
      gt = 1'b0;
    end else if (!a[31]) begin
      gt = (a[30:0] > b[30:0]);
    end else begin
      gt = (a[30:0] < b[30:0]);
    end
    return gt;
  endfunction

  // Pad the element table to the full 4-bit index range so the counter mux
  // never reaches past the packed input vector.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_elem
      if (gi < INPUT_NUM) begin : g_live
        assign elem_tbl[gi] = inputs[DATA_WIDTH*gi +: DATA_WIDTH];
      end else begin : g_pad
        assign elem_tbl[gi] = '0;
      end
    end
  endgenerate

  assign cur_elem = elem_tbl[counter_q];

  always_comb begin
    take_elem  = float_gt(cur_elem, best_q);
    best_d     = take_elem ? cur_elem  : best_q;
    best_idx_d = take_elem ? counter_q : best_idx_q;
  end

  generate
    for (genvar gi = 0; gi < INPUT_NUM; gi++) begin : g_onehot
      assign onehot_d[gi] = (best_idx_d == 4'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      counter_q      <= '0;
      best_q         <= '0;
      best_idx_q     <= '0;
      class_index_q  <= '0;
      class_value_q  <= '0;
      class_onehot_q <= '0;
      ack_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q    <= SCAN;
            best_q     <= elem_tbl[0];
            best_idx_q <= '0;
            counter_q  <= 4'd1;
          end
        end
        SCAN: begin
          if (!enable) begin
            // Abort: the partial best is simply overwritten by the next start.
            state_q   <= IDLE;
            counter_q <= '0;
          end else begin
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            counter_q  <= counter_q + 4'd1;
            if (counter_q == LAST_IDX) begin
              state_q        <= DONE;
              class_index_q  <= best_idx_d;
              class_value_q  <= best_d;
              class_onehot_q <= onehot_d;
              ack_q          <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!enable) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign classIndex  = class_index_q;
  assign classValue  = class_value_q;
  assign classOneHot = class_onehot_q;
  assign ackArg      = ack_q;

endmodule

// File: tb/tb_softmax_argmax.sv
// Randomised and directed bench for softmax_argmax against a real-valued
// argmax reference model.
module tb_softmax_argmax;
  localparam int N  = 10;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic [DW*N-1:0]   inputs = '0;
  logic [3:0]        classIndex;
  logic [DW-1:0]     classValue;
  logic [N-1:0]      classOneHot;
  logic              ackArg;

  int errors = 0;
  int checks = 0;
  logic [31:0] vec [N];

  softmax_argmax #(.DATA_WIDTH(DW), .INPUT_NUM(N)) dut (
    .clk(clk), .reset_n(reset_n), .inputs(inputs), .enable(enable),
    .classIndex(classIndex), .classValue(classValue),
    .classOneHot(classOneHot), .ackArg(ackArg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  function automatic real to_real(input logic [31:0] f);
    real m;
    int  e;
    e = int'(f[30:23]);
    if (e == 255)     m = 1.0e300;
    else if (e == 0)  m = (real'(f[22:0]) / 8388608.0) * (2.0 ** (-126));
    else              m = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return f[31] ? -m : m;
  endfunction

  function automatic int ref_argmax();
    int best = 0;
    for (int k = 1; k < N; k++)
      if (!is_nan(vec[k]) && !is_nan(vec[best]) && (to_real(vec[k]) > to_real(vec[best])))
        best = k;
    return best;
  endfunction

  task automatic load_vec();
    for (int k = 0; k < N; k++) inputs[DW*k +: DW] = vec[k];
  endtask

  task automatic fill(input logic [31:0] v);
    for (int k = 0; k < N; k++) vec[k] = v;
  endtask

  function automatic logic [31:0] rand_float(input bit neg_only);
    logic [31:0] f;
    f[31]    = neg_only ? 1'b1 : 1'($urandom_range(0, 1));
    f[30:23] = 8'($urandom_range(0, 254));
    f[22:0]  = 23'($urandom);
    return f;
  endfunction

  // Full run: start, wait for ack, compare with the model, then drop enable for one edge.
  task automatic run_check(input string tag);
    int cyc;
    int exp_idx;
    logic [N-1:0] exp_oh;
    load_vec();
    enable = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!ackArg && cyc < 14);
    exp_idx = ref_argmax();
    exp_oh  = '0;
    exp_oh[exp_idx] = 1'b1;
    check({tag, ".latency"}, 64'(cyc), 64'd10);
    check({tag, ".idx"}, 64'(classIndex), 64'(exp_idx));
    check({tag, ".val"}, 64'(classValue), 64'(vec[exp_idx]));
    check({tag, ".onehot"}, 64'(classOneHot), 64'(exp_oh));
    $display("run %s: idx=%0d val=0x%08h", tag, classIndex, classValue);
    enable = 1'b0;
    @(posedge clk); #1;
    check({tag, ".ack_drop"}, 64'(ackArg), 64'd0);
    check({tag, ".hold_idx"}, 64'(classIndex), 64'(exp_idx));
  endtask

  initial begin
    #1;
    check("reset.idx", 64'(classIndex), 64'd0);
    check("reset.val", 64'(classValue), 64'd0);
    check("reset.oh", 64'(classOneHot), 64'd0);
    check("reset.ack", 64'(ackArg), 64'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    fill(32'h3C23D70A); vec[7] = 32'h3F68F5C3;
    run_check("onehot7");
    check("onehot7.idx_const", 64'(classIndex), 64'd7);
    check("onehot7.val_const", 64'(classValue), 64'h3F68F5C3);
    check("onehot7.oh_const", 64'(classOneHot), 64'h080);

    fill(32'h3CA3D70A); vec[2] = 32'h3ECCCCCD; vec[5] = 32'h3ECCCCCD;
    run_check("tie");
    check("tie.idx_const", 64'(classIndex), 64'd2);
    check("tie.oh_const", 64'(classOneHot), 64'h004);

    fill(32'h3C23D70A); vec[0] = 32'h3F666666;
    run_check("max0");
    check("max0.idx_const", 64'(classIndex), 64'd0);
    fill(32'h3C23D70A); vec[9] = 32'h3F666666;
    run_check("max9");
    check("max9.idx_const", 64'(classIndex), 64'd9);

    for (int k = 0; k < N; k++) vec[k] = rand_float(1'b1);
    vec[3] = 32'h80000000; vec[6] = 32'h00000000;
    run_check("zeros");
    check("zeros.idx_const", 64'(classIndex), 64'd3);

    // Abort after a class-7 result.
    fill(32'h3C23D70A); vec[7] = 32'h3F68F5C3;
    run_check("pre_abort");
    fill(32'h3C23D70A); vec[1] = 32'h3F68F5C3;
    load_vec();
    enable = 1'b1;
    repeat (4) @(posedge clk);
    #1 enable = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort.ack", 64'(ackArg), 64'd0);
    end
    check("abort.idx", 64'(classIndex), 64'd7);
    check("abort.val", 64'(classValue), 64'h3F68F5C3);
    run_check("after_abort");

    // Asynchronous reset between edges mid-scan.
    fill(32'h3C23D70A); vec[4] = 32'h3F000000;
    load_vec();
    enable = 1'b1;
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("areset.idx", 64'(classIndex), 64'd0);
    check("areset.val", 64'(classValue), 64'd0);
    check("areset.oh", 64'(classOneHot), 64'd0);
    check("areset.ack", 64'(ackArg), 64'd0);
    enable = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    run_check("after_reset");

    vec[0] = 32'h7FC00001; for (int k = 1; k < N; k++) vec[k] = rand_float(1'b0);
    run_check("nan0");
    for (int k = 0; k < N; k++) vec[k] = rand_float(1'b0);
    vec[4] = 32'h7F800001; vec[8] = 32'h7F800000;
    run_check("nan_inf");

    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < N; k++) begin
        if (k > 0 && $urandom_range(0, 3) == 0) vec[k] = vec[$urandom_range(0, k - 1)];
        else vec[k] = rand_float(r % 4 == 0);
      end
      run_check($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
